copy_port_arbiter: RTL and testbench
====================================

# copy_port_arbiter

Shares the single 25-bit copy/memory port (addr, data, we, rd, virt) between three requesters: the ioctl download loader (0), the disk I/O engine (1) and the tape/save engine (2). The block grants ownership, sequences each access as the fixed setup/strobe/strobe/release pattern the memory side expects, returns read data and acknowledges. It sits between the requesters and the memory mux in the top level.

## Interface
- BURST_MAX, 256: accesses an owner may complete before it is pre-empted, if another requester is waiting.
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ce_cpu_p  in  1  clock enable; all state and outputs advance only on clk_sys edges where ce_cpu_p=1
- r_req  in  3  bit i: requester i wants ownership (level)
- r_gnt  out  3  one-hot ownership grant
- r_rd  in  3  bit i: one-ce-cycle read pulse from requester i
- r_we  in  3  bit i: one-ce-cycle write pulse from requester i
- r_virt  in  3  per-requester virtual-address flag
- r_addr  in  75  three 25-bit byte addresses; requester i uses [25i+24:25i]
- r_dout  in  48  three 16-bit write words; requester i uses [16i+15:16i]
- r_din  out  16  read data for the current owner
- r_ack  out  3  bit i: one-ce-cycle access-complete pulse
- m_addr  out  25  memory address
- m_dout  out  16  memory write data
- m_din  in  16  memory read data
- m_we  out  1  memory write strobe
- m_rd  out  1  memory read strobe
- m_virt  out  1  memory virtual flag
- busy  out  1  high whenever r_gnt≠0

## Operation
- Reset: asynchronous on reset_n low, regardless of ce. r_gnt=0, r_ack=0, r_din=0, m_addr=0, m_dout=0, m_we=0, m_rd=0, m_virt=0, busy=0. State goes to IDLE, burst count to 0, round-robin pointer to 1.
- IDLE:
  - No r_req bit set: stay in IDLE.
  - r_req[0] set: requester 0 wins (fixed highest priority).
  - Otherwise requesters 1 and 2 compete round-robin. The pointer names the preferred requester. When the pointer's requester is not requesting, the other one wins.
  - On a win: set the r_gnt bit, clear the burst count, go to HOLD. When the winner is 1 or 2, the pointer is set to the other of the two.
- HOLD (owner o):
  - r_we[o]: latch m_addr, m_dout and m_virt from slot o with the direction set to write, go to SETUP.
  - r_rd[o] alone: latch the same fields with the direction set to read, go to SETUP.
  - r_we[o] and r_rd[o] together: write wins; the read is dropped.
  - r_req[o] low with no op pulse: clear r_gnt, go to IDLE.
  - Burst count equal to BURST_MAX, another r_req bit set, and no op pulse: clear r_gnt, go to IDLE (pre-emption).
  - An op pulse takes priority over both release conditions.
- SETUP: assert the selected strobe (m_we or m_rd), go to STRB1.
- STRB1: strobe held, go to STRB2.
- STRB2: deassert the strobe. On a read, load r_din from m_din. Pulse r_ack[o]. Burst count increments, saturating at BURST_MAX. Go to HOLD.
- Ignored pulses:
  - Op pulses from non-owners are ignored.
  - Op pulses from the owner outside HOLD are ignored (protocol violation, no error flag).
- r_req[o] dropping mid-access does not abort the access. The release is taken in the next HOLD.
- m_addr, m_dout and m_virt hold their last values between accesses. r_din holds the last read value.

## Timing
- Latency is counted in ce edges. Op pulse sampled at edge k:
  - k: m_* fields latched.
  - k+1: strobe rises.
  - k+3: strobe falls, r_ack=1, r_din valid.
  - k+4: r_ack=0.
- The strobe is high for exactly 2 ce periods, and address/data are stable one ce period before it rises.
- The earliest next op pulse from the same owner is accepted at edge k+4, giving 4 ce periods per access.
- Grant latency from IDLE: r_req sampled at edge j gives r_gnt at edge j.
- Release to a new grant: ownership released at edge j (r_gnt=0, state IDLE) gives the new grant at edge j+1. r_gnt is therefore 0 for one ce period between owners.
- Non-ce cycles freeze everything except the asynchronous reset.
- Reset mid-access: strobes drop immediately, no ack is issued, and the access is lost.

## Test plan
- Single read by requester 1 at 25'h000200 with m_din=16'h1234: m_rd high at k+1 and k+2, r_ack[1] at k+3, r_din=16'h1234, 4-ce cadence on back-to-back reads.
- r_req=3'b110 held, each owner issuing continuous writes with BURST_MAX=4: grants alternate 1,2,1,… every 4 acks, with one zero-grant ce period between owners.
- Requester 0 asserts r_req while requester 2 is in STRB1: requester 2's access completes and is acked, then requester 0 is granted after requester 2's next release.
- r_we[1] and r_rd[1] in the same pulse with r_dout slot 1=16'hBEEF: a write of BEEF occurs, m_rd is never asserted, and r_din is unchanged.
- reset_n low during STRB1: all outputs are 0 with no clock; after release, busy=0 and a new request from 2 is granted with the round-robin pointer at 1 (2 still wins when it requests alone).
- A requester-2 op pulse while r_gnt=3'b010: ignored, no strobe, no r_ack[2].

Source files
------------

// File: rtl/copy_port_arbiter.sv
// Arbitrates the shared 25-bit copy/memory port between loader (0), disk (1) and tape (2).
// Each access runs setup/strobe/strobe/release; ack and read data appear 3 ce edges after the op pulse.
module copy_port_arbiter #(
  parameter int BURST_MAX = 256
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_cpu_p,
  input  logic [2:0]  r_req,
  output logic [2:0]  r_gnt,
  input  logic [2:0]  r_rd,
  input  logic [2:0]  r_we,
  input  logic [2:0]  r_virt,
  input  logic [74:0] r_addr,
  input  logic [47:0] r_dout,
  output logic [15:0] r_din,
  output logic [2:0]  r_ack,
  output logic [24:0] m_addr,
  output logic [15:0] m_dout,
  input  logic [15:0] m_din,
  output logic        m_we,
  output logic        m_rd,
  output logic        m_virt,
  output logic        busy
);

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    SETUP = 3'd2,
    STRB1 = 3'd3,
    STRB2 = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [1:0]    rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_wr_q, is_wr_d;
  logic [2:0]    ack_q, ack_d;
  logic [15:0]   din_q, din_d;
  logic [24:0]   addr_q, addr_d;
  logic [15:0]   dout_q, dout_d;
  logic          virt_q, virt_d;
  logic          we_q, we_d;
  logic          rd_q, rd_d;

  // Per-owner view of the requester slots.
  logic [24:0] sel_addr;
  logic [15:0] sel_dout;
  logic        sel_virt;
  logic        sel_we;
  logic        sel_rd;
  logic        sel_req;
  logic        others_req;

  always_comb begin
    sel_addr = r_addr[24:0];
    sel_dout = r_dout[15:0];
    sel_virt = r_virt[0];
    sel_we   = r_we[0];
    sel_rd   = r_rd[0];
    sel_req  = r_req[0];
    case (owner_q)
      2'd1: begin
        sel_addr = r_addr[49:25];
        sel_dout = r_dout[31:16];
        sel_virt = r_virt[1];
        sel_we   = r_we[1];
        sel_rd   = r_rd[1];
        sel_req  = r_req[1];
      end
      2'd2: begin
        sel_addr = r_addr[74:50];
        sel_dout = r_dout[47:32];
        sel_virt = r_virt[2];
        sel_we   = r_we[2];
        sel_rd   = r_rd[2];
        sel_req  = r_req[2];
      end
      default: ;
    endcase
  end

  assign others_req = |(r_req & ~gnt_q);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    ack_d   = 3'b000;
    din_d   = din_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    virt_d  = virt_q;
    we_d    = we_q;
    rd_d    = rd_q;

    case (state_q)
      IDLE: begin
        if (r_req[0]) begin
          gnt_d   = 3'b001;
          owner_d = 2'd0;
          cnt_d   = '0;
          state_d = HOLD;
        end else if (r_req[2:1] != 2'b00) begin
          // rr_q names the preferred disk/tape requester; the loser becomes preferred next time.
          if (r_req[1] && (!r_req[2] || rr_q == 2'd1)) begin
            gnt_d   = 3'b010;
            owner_d = 2'd1;
            rr_d    = 2'd2;
          end else begin
            gnt_d   = 3'b100;
            owner_d = 2'd2;
            rr_d    = 2'd1;
          end
          cnt_d   = '0;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (sel_we || sel_rd) begin
          addr_d  = sel_addr;
          dout_d  = sel_dout;
          virt_d  = sel_virt;
          is_wr_d = sel_we;
          state_d = SETUP;
        end else if (!sel_req || (cnt_q == BMAX && others_req)) begin
          gnt_d   = 3'b000;
          state_d = IDLE;
        end
      end

      SETUP: begin
        we_d    = is_wr_q;
        rd_d    = !is_wr_q;
        state_d = STRB1;
      end

      STRB1: state_d = STRB2;

      STRB2: begin
        we_d  = 1'b0;
        rd_d  = 1'b0;
        ack_d = gnt_q;
        if (!is_wr_q) din_d = m_din;
        if (cnt_q != BMAX) cnt_d = cnt_q + CW'(1);
        state_d = HOLD;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      gnt_q   <= 3'b000;
      rr_q    <= 2'd1;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      ack_q   <= 3'b000;
      din_q   <= 16'h0000;
      addr_q  <= 25'h0;
      dout_q  <= 16'h0000;
      virt_q  <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else if (ce_cpu_p) begin
      state_q <= state_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      ack_q   <= ack_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      virt_q  <= virt_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
    end
  end

  assign r_gnt  = gnt_q;
  assign r_ack  = ack_q;
  assign r_din  = din_q;
  assign m_addr = addr_q;
  assign m_dout = dout_q;
  assign m_virt = virt_q;
  assign m_we   = we_q;
  assign m_rd   = rd_q;
  assign busy   = |gnt_q;

endmodule

// File: tb/tb_copy_port_arbiter.sv
// Directed sequence with random addresses/data, checked against a memory scoreboard and grant model.
`define CHK(t, o, e) chk(t, 32'(o), 32'(e))

module tb_copy_port_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ce_cpu_p;
    logic [2:0]  r_req, r_gnt, r_rd, r_we, r_virt, r_ack;
    logic [74:0] r_addr;
    logic [47:0] r_dout;
    logic [15:0] r_din, m_dout, m_din;
    logic [24:0] m_addr;
    logic        m_we, m_rd, m_virt, busy;

    copy_port_arbiter #(.BURST_MAX(4)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_cpu_p(ce_cpu_p),
        .r_req(r_req), .r_gnt(r_gnt), .r_rd(r_rd), .r_we(r_we), .r_virt(r_virt),
        .r_addr(r_addr), .r_dout(r_dout), .r_din(r_din), .r_ack(r_ack),
        .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din), .m_we(m_we), .m_rd(m_rd),
        .m_virt(m_virt), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Reference state: memory contents, last read word, expected grant and preferred requester.
    logic [15:0] mem [logic [24:0]];
    logic [15:0] din_exp;
    logic [2:0]  gnt_exp;
    int          rr_exp;
    logic [24:0] maddr_exp;

    function automatic logic [15:0] mem_rd(input logic [24:0] a);
        if (mem.exists(a)) return mem[a];
        return a[15:0] ^ 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        m_din = mem_rd(m_addr);
    endtask

    task automatic expect_grant(input string tag);
        if (r_req[0])                  gnt_exp = 3'b001;
        else if (r_req[1] && r_req[2]) gnt_exp = (rr_exp == 1) ? 3'b010 : 3'b100;
        else if (r_req[1])             gnt_exp = 3'b010;
        else if (r_req[2])             gnt_exp = 3'b100;
        else                           gnt_exp = 3'b000;
        if (gnt_exp == 3'b010) rr_exp = 2;
        if (gnt_exp == 3'b100) rr_exp = 1;
        tick();
        `CHK({tag, ":gnt"}, r_gnt, gnt_exp);
        `CHK({tag, ":busy"}, busy, gnt_exp != 3'b000);
    endtask

    task automatic expect_release(input string tag);
        tick();
        gnt_exp = 3'b000;
        `CHK({tag, ":rel_gnt"}, r_gnt, 3'b000);
        `CHK({tag, ":rel_busy"}, busy, 1'b0);
    endtask

    task automatic access(input int o, input bit wr, input bit rd, input logic [24:0] a,
                          input logic [15:0] d, input bit v, input logic [2:0] req_mid,
                          input int freeze, input string tag);
        logic [2:0] bit_o;
        logic [1:0] strb;
        bit_o    = 3'b000;
        bit_o[o] = 1'b1;
        strb     = wr ? 2'b10 : 2'b01;
        r_addr[25*o +: 25] = a;
        r_dout[16*o +: 16] = d;
        r_virt[o] = v;
        r_we = wr ? bit_o : 3'b000;
        r_rd = rd ? bit_o : 3'b000;
        tick();
        r_we = 3'b000;
        r_rd = 3'b000;
        maddr_exp = a;
        `CHK({tag, ":k_ack"}, r_ack, 3'b000);
        `CHK({tag, ":k_addr"}, m_addr, a);
        `CHK({tag, ":k_dout"}, m_dout, d);
        `CHK({tag, ":k_virt"}, m_virt, v);
        `CHK({tag, ":k_strb"}, {m_we, m_rd}, 2'b00);
        tick();
        `CHK({tag, ":k1_strb"}, {m_we, m_rd}, strb);
        r_req = req_mid;
        for (int i = 0; i < freeze; i++) begin
            ce_cpu_p = 1'b0;
            tick();
            `CHK({tag, ":frz_strb"}, {m_we, m_rd}, strb);
            `CHK({tag, ":frz_ack"}, r_ack, 3'b000);
        end
        ce_cpu_p = 1'b1;
        tick();
        `CHK({tag, ":k2_strb"}, {m_we, m_rd}, strb);
        `CHK({tag, ":k2_ack"}, r_ack, 3'b000);
        tick();
        if (wr) mem[a] = d;
        else    din_exp = mem_rd(a);
        `CHK({tag, ":k3_strb"}, {m_we, m_rd}, 2'b00);
        `CHK({tag, ":k3_ack"}, r_ack, bit_o);
        `CHK({tag, ":k3_din"}, r_din, din_exp);
        `CHK({tag, ":k3_gnt"}, r_gnt, gnt_exp);
    endtask

    function automatic int owner_of(input logic [2:0] g);
        return (g == 3'b010) ? 1 : (g == 3'b100) ? 2 : 0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] a;
        logic [15:0] d;
        reset_n = 1'b0; ce_cpu_p = 1'b1;
        r_req = 3'b000; r_rd = 3'b000; r_we = 3'b000; r_virt = 3'b000;
        r_addr = '0; r_dout = '0; m_din = 16'h0;
        din_exp = 16'h0; gnt_exp = 3'b000; rr_exp = 1; maddr_exp = '0;
        repeat (3) @(posedge clk_sys);
        #1;
        `CHK("rst:gnt", r_gnt, 3'b000);
        `CHK("rst:ack", r_ack, 3'b000);
        `CHK("rst:din", r_din, 16'h0);
        `CHK("rst:addr", m_addr, 25'h0);
        `CHK("rst:strb", {m_we, m_rd, m_virt}, 3'b000);
        `CHK("rst:busy", busy, 1'b0);
        checks++;
        if (r_gnt !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $error("FAIL rst_inline gnt=%0h busy=%0b", r_gnt, busy);
        end
        reset_n = 1'b1;
        tick();

        // Burst alternation between disk and tape, 4 accesses each.
        r_req = 3'b110;
        expect_grant("burst_first");
        `CHK("burst_first_is_1", r_gnt, 3'b010);
        for (int rnd = 0; rnd < 4; rnd++) begin
            `CHK("burst_owner", owner_of(r_gnt), (rnd % 2 == 0) ? 1 : 2);
            for (int n = 0; n < 4; n++) begin
                a = 25'($urandom); d = 16'($urandom);
                access(owner_of(gnt_exp), 1'b1, 1'b0, a, d, 1'($urandom), 3'b110, 0, "burst_wr");
            end
            expect_release("burst");
            expect_grant("burst_next");
        end
        r_req = 3'b000;
        expect_release("burst_end");

        // Single read at 0x200 then back-to-back reads, one with ce gaps.
        mem[25'h000200] = 16'h1234;
        r_req = 3'b010;
        expect_grant("rd_grant");
        access(1, 1'b0, 1'b1, 25'h000200, 16'($urandom), 1'b0, 3'b010, 0, "rd200");
        `CHK("rd200_value", r_din, 16'h1234);
        checks++;
        if (r_din !== 16'h1234) begin
            errors++;
            $error("FAIL rd200_inline din=%0h", r_din);
        end
        for (int n = 0; n < 3; n++)
            access(1, 1'b0, 1'b1, 25'($urandom), 16'($urandom), 1'($urandom), 3'b010,
                   (n == 1) ? 3 : 0, "rd_b2b");
        a = 25'($urandom); d = 16'($urandom);
        access(1, 1'b1, 1'b0, a, d, 1'b1, 3'b010, 0, "wr_then");
        access(1, 1'b0, 1'b1, a, 16'h0, 1'b0, 3'b010, 0, "rd_back");

        // Simultaneous write and read: write wins, r_din unchanged.
        a = 25'h0ABCDE;
        access(1, 1'b1, 1'b1, a, 16'hBEEF, 1'b0, 3'b010, 0, "wr_rd_both");
        access(1, 1'b0, 1'b1, a, 16'h0, 1'b0, 3'b010, 0, "beef_back");
        `CHK("beef_value", r_din, 16'hBEEF);
        checks++;
        if (r_din !== 16'hBEEF) begin
            errors++;
            $error("FAIL beef_inline din=%0h", r_din);
        end

        // Op pulse from a non-owner is ignored.
        r_addr[74:50] = 25'h1FFFFFF;
        r_rd = 3'b100;
        tick();
        r_rd = 3'b000;
        for (int n = 0; n < 4; n++) begin
            `CHK("nonowner_strb", {m_we, m_rd}, 2'b00);
            `CHK("nonowner_ack", r_ack, 3'b000);
            `CHK("nonowner_addr", m_addr, maddr_exp);
            tick();
        end
        access(1, 1'b0, 1'b1, 25'($urandom), 16'h0, 1'b0, 3'b010, 0, "after_ignored");
        r_req = 3'b000;
        expect_release("t6_end");

        // Loader requests while tape is mid-access; tape completes, loader waits for release.
        r_req = 3'b100;
        expect_grant("t3_grant2");
        access(2, 1'b1, 1'b0, 25'($urandom), 16'($urandom), 1'b0, 3'b101, 0, "t3_wr2");
        tick();
        `CHK("t3_still2", r_gnt, 3'b100);
        r_req = 3'b001;
        expect_release("t3");
        expect_grant("t3_grant0");
        `CHK("t3_is0", r_gnt, 3'b001);
        checks++;
        if (r_gnt !== 3'b001) begin
            errors++;
            $error("FAIL t3_is0_inline gnt=%0h", r_gnt);
        end
        access(0, 1'b0, 1'b1, 25'($urandom), 16'h0, 1'b1, 3'b001, 0, "t3_rd0");
        r_req = 3'b000;
        expect_release("t3_end");

        // Reset during STRB1.
        r_req = 3'b100;
        expect_grant("t5_grant");
        r_addr[74:50] = 25'h0001234;
        r_dout[47:32] = 16'hA5A5;
        r_virt[2] = 1'b1;
        r_we = 3'b100;
        tick();
        r_we = 3'b000;
        tick();
        `CHK("t5_strb1", m_we, 1'b1);
        #2;
        reset_n = 1'b0;
        r_req = 3'b000;
        #1;
        `CHK("t5_rst_gnt", r_gnt, 3'b000);
        `CHK("t5_rst_ack", r_ack, 3'b000);
        `CHK("t5_rst_din", r_din, 16'h0);
        `CHK("t5_rst_addr", m_addr, 25'h0);
        `CHK("t5_rst_dout", m_dout, 16'h0);
        `CHK("t5_rst_strb", {m_we, m_rd, m_virt}, 3'b000);
        `CHK("t5_rst_busy", busy, 1'b0);
        rr_exp = 1; din_exp = 16'h0; gnt_exp = 3'b000;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        `CHK("t5_post_busy", busy, 1'b0);
        `CHK("t5_post_ack", r_ack, 3'b000);
        r_req = 3'b110;
        expect_grant("t5_ptr");
        `CHK("t5_ptr_is1", r_gnt, 3'b010);
        checks++;
        if (r_gnt !== 3'b010) begin
            errors++;
            $error("FAIL t5_ptr_inline gnt=%0h", r_gnt);
        end
        r_req = 3'b000;
        expect_release("t5_a");
        r_req = 3'b100;
        expect_grant("t5_alone2");
        `CHK("t5_alone2_is2", r_gnt, 3'b100);
        checks++;
        if (r_gnt !== 3'b100) begin
            errors++;
            $error("FAIL t5_alone2_inline gnt=%0h", r_gnt);
        end
        r_req = 3'b000;
        expect_release("t5_b");
        r_req = 3'b110;
        expect_grant("t5_ptr_again");
        r_req = 3'b000;
        expect_release("t5_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
